fpu_issue_ctrl: RTL and testbench

Sequential front end for the combinational `fpu_top` arithmetic unit. Accepts operation requests over a valid/ready handshake, buffers them in a small FIFO, and issues one at a time to `fpu_top` from registered operands. It captures each result and its exception flags into an output register presented over a second valid/ready handshake, and keeps sticky exception status for software.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fpu_req_fifo.sv | 48 ++++
 rtl/fpu_top.sv | 66 ++++++
 rtl/fpu_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared op codes, issue FSM states and request record sizing for the FPU front end.
package fpu_pkg;

    localparam logic [1:0] FPU_OP_ADD = 2'b00;
    localparam logic [1:0] FPU_OP_SUB = 2'b01;
    localparam logic [1:0] FPU_OP_MUL = 2'b10;
    localparam logic [1:0] FPU_OP_DIV = 2'b11;

    localparam logic [31:0] FPU_QNAN = 32'h7FC0_0000;

    // Request record is {op, a, b, tag}; add the caller's TAG_W to this.
    localparam int FPU_REQ_FIXED_W = 2 + 32 + 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } fsm_state_e;

endpackage

// File: rtl/fpu_req_fifo.sv
// fpu_req_fifo: synchronous request FIFO with wrap-bit pointers.
//   clk, rst         clock and synchronous active-high reset
//   push_i, data_i   write one record (ignored while full)
//   pop_i            drop the head record (ignored while empty)
//   data_o           head record
//   full_o, empty_o  occupancy status
module fpu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 70
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic         do_push, do_pop;

    // Same slot with opposite wrap bits means the writer has lapped the reader.
    assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign empty_o = wr_q == rd_q;
    assign data_o  = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_top.sv
// fpu_top: combinational single-precision arithmetic unit (multiply datapath).
//   op                 operation code; only multiply is implemented, others flag error
//   a, b               IEEE-754 single-precision operands
//   result             product, round-to-nearest-even, zero/denormal inputs read as zero
//   error              invalid operation (NaN input, inf x 0, unsupported op)
//   underflow          result too small, flushed to signed zero
//   overflow           result too large, saturated to signed infinity
module fpu_top
    import fpu_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        error,
    output logic        underflow,
    output logic        overflow
);

    logic              sign, unsupported;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, rnd_up;
    logic [47:0]       prod, norm;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic signed [9:0] exp_n;

    always_comb begin
        unsupported = op inside {FPU_OP_ADD, FPU_OP_SUB, FPU_OP_DIV};
        sign        = a[31] ^ b[31];
        a_zero      = a[30:23] == 8'h00;
        b_zero      = b[30:23] == 8'h00;
        a_inf       = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf       = (b[30:23] == 8'hFF) && (b[22:0] == '0);
        a_nan       = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan       = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        prod        = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        // Normalise so the leading one sits at bit 47 before rounding.
        norm        = prod[47] ? prod : {prod[46:0], 1'b0};
        rnd_up      = norm[23] && ((norm[22:0] != '0) || norm[24]);
        mant_r      = {1'b0, norm[47:24]} + 25'(rnd_up);
        frac        = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        exp_n       = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
                    + $signed({9'd0, prod[47]}) + $signed({9'd0, mant_r[24]});
        result      = '0;
        error       = 1'b0;
        underflow   = 1'b0;
        overflow    = 1'b0;
        if (unsupported || a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            error  = 1'b1;
            result = FPU_QNAN;
        end else if (a_inf || b_inf) begin
            result = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            result = {sign, 31'd0};
        end else if (exp_n >= 10'sd255) begin
            overflow = 1'b1;
            result   = {sign, 8'hFF, 23'd0};
        end else if (exp_n <= 10'sd0) begin
            underflow = 1'b1;
            result    = {sign, 31'd0};
        end else begin
            result = {sign, exp_n[7:0], frac};
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: queues FPU requests, issues them one at a time to fpu_top and
// returns registered results with sticky exception status.
//   in_valid/in_ready/in_op/in_a/in_b/in_tag   request handshake and payload
//   out_valid/out_ready/out_result/out_tag     result handshake and payload
//   out_error/out_underflow/out_overflow       flags captured with the result
//   sticky_flags {error, overflow, underflow}  OR of all captured flags
//   sticky_clr                                 clears sticky_flags (a same-edge capture wins)
//   busy                                       work queued or in flight
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_error,
    output logic             out_underflow,
    output logic             out_overflow,
    output logic [2:0]       sticky_flags,
    input  logic             sticky_clr,
    output logic             busy
);

    localparam int REQ_W = FPU_REQ_FIXED_W + TAG_W;

    fsm_state_e       state_q, state_d;
    logic             fifo_full, fifo_empty, pop, capture;
    logic [REQ_W-1:0] head;
    logic [1:0]       op_q;
    logic [31:0]      a_q, b_q, res_q, fpu_res;
    logic [TAG_W-1:0] tag_q, otag_q;
    logic             valid_q, err_q, uf_q, of_q;
    logic             fpu_err, fpu_uf, fpu_of;
    logic [2:0]       sticky_q, flags_now;

    assign in_ready = !fifo_full;

    fpu_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REQ_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid && in_ready),
        .pop_i   (pop),
        .data_i  ({in_op, in_a, in_b, in_tag}),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    fpu_top u_fpu (
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .result    (fpu_res),
        .error     (fpu_err),
        .underflow (fpu_uf),
        .overflow  (fpu_of)
    );

    assign flags_now = {fpu_err, fpu_of, fpu_uf};

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                pop     = !fifo_empty;
                state_d = fifo_empty ? IDLE : ISSUE;
            end
            ISSUE: begin
                capture = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                pop     = out_ready && !fifo_empty;
                state_d = !out_ready ? DONE : (fifo_empty ? IDLE : ISSUE);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            valid_q  <= 1'b0;
            res_q    <= '0;
            otag_q   <= '0;
            err_q    <= 1'b0;
            uf_q     <= 1'b0;
            of_q     <= 1'b0;
            sticky_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop) {op_q, a_q, b_q, tag_q} <= head;
            if (capture) begin
                res_q  <= fpu_res;
                otag_q <= tag_q;
                err_q  <= fpu_err;
                uf_q   <= fpu_uf;
                of_q   <= fpu_of;
            end
            // Every delivered result drops valid, even when the next issue starts at once.
            valid_q  <= capture || (valid_q && !out_ready);
            sticky_q <= capture ? ((sticky_clr ? 3'b000 : sticky_q) | flags_now)
                                : (sticky_clr ? 3'b000 : sticky_q);
        end
    end

    assign out_valid     = valid_q;
    assign out_result    = res_q;
    assign out_tag       = otag_q;
    assign out_error     = err_q;
    assign out_underflow = uf_q;
    assign out_overflow  = of_q;
    assign sticky_flags  = sticky_q;
    assign busy          = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: table-driven, scoreboarded bench for fpu_issue_ctrl.
module tb_fpu_issue_ctrl;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [2:0]  flg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        out_error, out_underflow, out_overflow;
    logic [2:0]  sticky_flags;
    logic        sticky_clr = 1'b0;
    logic        busy;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    vec_t vecs[11];
    exp_t sb[$];
    int   hs_cyc[$];
    exp_t mon_e;
    logic [2:0] exp_sticky = '0;

    fpu_issue_ctrl #(.FIFO_DEPTH(4), .TAG_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_tag       (out_tag),
        .out_error     (out_error),
        .out_underflow (out_underflow),
        .out_overflow  (out_overflow),
        .sticky_flags  (sticky_flags),
        .sticky_clr    (sticky_clr),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // flg is {error, underflow, overflow}; sticky is {error, overflow, underflow}.
    function automatic logic [2:0] to_sticky(input logic [2:0] f);
        return {f[2], f[0], f[1]};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("spurious_result", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_result", out_result, mon_e.res);
                chk("out_tag", 32'(out_tag), 32'(mon_e.tag));
                chk("out_flags", 32'({out_error, out_underflow, out_overflow}), 32'(mon_e.flg));
                exp_sticky = exp_sticky | to_sticky(mon_e.flg);
                chk("sticky_at_result", 32'(sticky_flags), 32'(exp_sticky));
            end
        end
    end

    // Called one step after an edge; leaves in_valid high after the accepting edge.
    task automatic send(input int idx, input logic [3:0] tag);
        int n = 0;
        in_valid = 1'b1;
        in_op    = vecs[idx].op;
        in_a     = vecs[idx].a;
        in_b     = vecs[idx].b;
        in_tag   = tag;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_timeout", 32'(n < 200), 32'd1);
        sb.push_back('{res: vecs[idx].res, tag: tag, flg: vecs[idx].flg});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(n < 500), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b10, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 3'b000};
        vecs[1]  = '{2'b10, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100};
        vecs[2]  = '{2'b10, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000};
        vecs[3]  = '{2'b10, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 3'b000};
        vecs[4]  = '{2'b10, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b001};
        vecs[5]  = '{2'b10, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b010};
        vecs[6]  = '{2'b10, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b100};
        vecs[7]  = '{2'b10, 32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 3'b000};
        vecs[8]  = '{2'b10, 32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 3'b000};
        vecs[9]  = '{2'b10, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000};
        vecs[10] = '{2'b10, 32'hBF80_0000, 32'hBF80_0000, 32'h3F80_0000, 3'b000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_flags", 32'({out_error, out_underflow, out_overflow}), 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single multiply latency: accept edge 0, valid after edge 2
        out_ready = 1'b1;
        send(0, 4'd3);
        in_valid = 1'b0;
        chk("lat_busy_e0", 32'(busy), 32'd1);
        chk("lat_valid_e0", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_e1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_e2", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("lat_valid_after_hs", 32'(out_valid), 32'd0);
        chk("lat_idle", 32'(busy), 32'd0);

        // Table of operand patterns, back-to-back
        for (int i = 0; i < 11; i++) send(i, 4'(i));
        in_valid = 1'b0;
        drain();
        chk("sticky_after_table", 32'(sticky_flags), 32'b111);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        exp_sticky = '0;
        chk("sticky_cleared", 32'(sticky_flags), 32'd0);

        // Error stays sticky across later clean results
        send(1, 4'd9);
        send(2, 4'd10);
        in_valid = 1'b0;
        drain();
        chk("sticky_err_holds", 32'(sticky_flags), 32'b100);

        // Backpressure: five requests with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(i, 4'(i));
        in_valid = 1'b0;
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_stall_result", out_result, vecs[0].res);
            chk("bp_stall_tag", 32'(out_tag), 32'd0);
        end
        hs_cyc.delete();
        out_ready = 1'b1;
        chk("bp_full_during_pop", 32'(in_ready), 32'd0);
        drain();
        chk("bp_result_count", 32'(hs_cyc.size()), 32'd5);
        for (int i = 1; i < hs_cyc.size(); i++) chk("bp_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);

        // Clear coincides with a capture: captured flags win
        chk("pre_clr_sticky", 32'(sticky_flags), 32'(exp_sticky));
        send(5, 4'd5);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        exp_sticky = '0;
        chk("clr_vs_capture", 32'(sticky_flags), 32'b001);
        drain();

        // Reset while ISSUE holds one request and two more are queued
        out_ready = 1'b0;
        send(2, 4'd11);
        send(3, 4'd12);
        send(7, 4'd13);
        send(9, 4'd14);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        sb.delete();
        exp_sticky = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_sticky", 32'(sticky_flags), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_result", 32'(out_valid), 32'd0);

        // Pipe still works after the mid-flight reset
        send(10, 4'd15);
        in_valid = 1'b0;
        drain();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
